// File: rtl/instruction_queue_pkg.sv
// Shared fetch/decode types: the NOP used to mask an empty queue and the
// {pc, instruction} packet carried from fetch to decode.
package instruction_queue_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instruction;
  } fetch_packet;

endpackage

// File: rtl/instruction_queue.sv
// Circular FIFO of fetched {pc, instruction} pairs feeding instruction_decode.
// Emptied in one cycle by flush; outputs show a NOP at pc 0 while empty.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // The storage element is the shared fetch_packet, so the PC width is tied
  // to the package and DEPTH must let the pointers wrap naturally.
  if (XLEN != FETCH_XLEN) begin : g_bad_xlen
    $error("instruction_queue: XLEN must equal FETCH_XLEN");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_queue: DEPTH must be a power of two and at least 2");
  end

  fetch_packet     mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;
  logic            pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on occupancy, never on out_ready, so
  // there is no combinational path from decode back to fetch.
  always_comb begin
    in_ready  = (count != FULL_COUNT);
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Contents need no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[tail] <= '{pc: in_pc, instruction: in_instruction};
    end
  end

  always_comb begin
    if (out_valid) begin
      out_instruction = mem[head].instruction;
      out_pc          = mem[head].pc;
    end else begin
      out_instruction = NOP_INSTRUCTION;
      out_pc          = '0;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: a reference queue of expected
// {pc, instruction} pairs is checked against every handshake and every cycle.
module tb_instruction_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instruction;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  logic [63:0] exp_q[$];
  int n_cmp;
  int n_err;

  instruction_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .count           (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs, check any pop against the scoreboard head,
  // advance the model at the edge, then check the post-edge state.
  task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] instr,
                      input logic rdy, input logic fl, input logic rst);
    bit do_push;
    bit do_pop;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = instr;
    out_ready      = rdy;
    flush          = fl;
    reset          = rst;
    #1;
    do_push = v && (exp_q.size() != DEPTH);
    do_pop  = rdy && (exp_q.size() != 0);
    if (do_pop) check_eq("pop_data", {out_pc, out_instruction}, exp_q[0]);
    @(posedge clk);
    #1;
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, instr});
    end
    check_eq("count", 64'(count), 64'(exp_q.size()));
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
    if (exp_q.size() == 0)
      check_eq("empty_out", {out_pc, out_instruction}, {32'h0, 32'h00000013});
    else
      check_eq("head_out", {out_pc, out_instruction}, exp_q[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_only(input logic [XLEN-1:0] pc, input logic [31:0] instr);
    step(1'b1, pc, instr, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instruction = '0;

    // reset then idle
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // single push, held output, then consume
    push_only(32'h100, 32'h00500093);
    check_eq("first_pc", 64'(out_pc), 64'h100);
    idle(3);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("drained", 64'(count), 64'd0);

    // fill to DEPTH, 9th offer ignored, then drain in order
    for (int i = 0; i < DEPTH; i++) push_only(XLEN'(i * 4), 32'h01000013 + 32'(i));
    check_eq("full_ready", 64'(in_ready), 64'd0);
    push_only(32'hDEAD, 32'hBAD0BAD0);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("order_pc", 64'(out_pc), 64'(i * 4));
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      if (i == 0) check_eq("ready_after_pop", 64'(in_ready), 64'd1);
    end

    // count=3 then 20 cycles of simultaneous push+pop
    for (int i = 0; i < 3; i++) push_only(XLEN'(32'h400 + i * 4), 32'h00100093 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, XLEN'(32'h500 + i * 4), 32'h00200113 + 32'(i), 1'b1, 1'b0, 1'b0);
      check_eq("steady_count", 64'(count), 64'd3);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush at count=5 with a concurrent push and pop offered
    for (int i = 0; i < 5; i++) push_only(XLEN'(32'h600 + i * 4), 32'h00300193 + 32'(i));
    step(1'b1, 32'h0BAD, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    push_only(32'h700, 32'h00400213);
    check_eq("post_flush_pc", 64'(out_pc), 64'h700);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // reset mid-stream at count=6
    for (int i = 0; i < 6; i++) push_only(XLEN'(32'h800 + i * 4), 32'h00500293 + 32'(i));
    step(1'b1, 32'h0BAD, 32'hEEEEEEEE, 1'b1, 1'b0, 1'b1);
    check_eq("reset_count", 64'(count), 64'd0);
    push_only(32'h200, 32'h00600313);
    push_only(32'h204, 32'h00700393);
    check_eq("post_reset_pc", 64'(out_pc), 64'h200);

    // random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), XLEN'($urandom), $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'b0);
    end
    while (exp_q.size() != 0 && n_cmp < 100000) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("final_empty", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
